// File: rtl/ad_frame_merger.sv
`default_nettype none
// ============================================================================
// Module   : ad_frame_merger
// Purpose  : N-channel ADC frame merger. Serves one complete frame per
//            eligible channel in round-robin order and writes it to the
//            downstream data FIFO as: header, FRAME_WORDS payload words, tail.
//            A frame is never abandoned except by reset / soft_path_rst.
// Ports    : clk_100m, reset (async, active-high), soft_path_rst (sync clear)
//            pack_en, chan_mask[N], board_number[4]     control
//            ch_empty[N], ch_rden[N], ch_data[32*N]     per-channel FIFO side
//            data_fifo_almost_full, data_fifo_wr_en,
//            data_fifo_wr_din[32]                       downstream FIFO side
//            busy, cur_chan[4]                          status
// Config   : define FRAME_CSUM_EN to fill the tail checksum field with the
//            16-bit wrapping sum of (word[31:16] + word[15:0]) over the
//            payload; otherwise the field is 16'h0000.
// Revision : 1.0 - initial release
// ============================================================================
module ad_frame_merger #(
  parameter int ADC_CHANEL  = 4,
  parameter int FRAME_WORDS = 64,
  parameter int FNUM_W      = 16
) (
  input  logic                    clk_100m,
  input  logic                    reset,
  input  logic                    soft_path_rst,
  input  logic                    pack_en,
  input  logic [ADC_CHANEL-1:0]   chan_mask,
  input  logic [3:0]              board_number,
  input  logic [ADC_CHANEL-1:0]   ch_empty,
  output logic [ADC_CHANEL-1:0]   ch_rden,
  input  logic [32*ADC_CHANEL-1:0] ch_data,
  input  logic                    data_fifo_almost_full,
  output logic                    data_fifo_wr_en,
  output logic [31:0]             data_fifo_wr_din,
  output logic                    busy,
  output logic [3:0]              cur_chan
);

  localparam int C_IDX_W = (ADC_CHANEL > 1) ? $clog2(ADC_CHANEL) : 1;
  localparam int C_CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [C_CNT_W-1:0] C_FRAME_WORDS = C_CNT_W'(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t               r_state;
  logic [C_IDX_W-1:0]   r_sel;
  logic [C_IDX_W-1:0]   r_rr_ptr;
  logic [C_CNT_W-1:0]   r_issued;
  logic [C_CNT_W-1:0]   r_written;
  logic                 r_rd_d1;
  logic [FNUM_W-1:0]    r_fcnt [ADC_CHANEL];

  logic [ADC_CHANEL-1:0] w_elig;
  logic                  w_hit;
  logic [C_IDX_W-1:0]    w_pick;
  logic [31:0]           w_sel_dat;
  logic                  w_sel_empty;
  logic [15:0]           w_sel_fcnt;
  logic [15:0]           w_csum;
  logic                  w_rd_go;

  // --------------------------------------------------------------------------
  // Round-robin scan: first eligible channel starting at rr_ptr+1 (mod N).
  // --------------------------------------------------------------------------
  assign w_elig = chan_mask & ~ch_empty;

  always_comb begin
    w_hit  = 1'b0;
    w_pick = '0;
    for (int i = 1; i <= ADC_CHANEL; i++) begin
      for (int k = 0; k < ADC_CHANEL; k++) begin
        if (!w_hit && w_elig[k] && (((int'(r_rr_ptr) + i) % ADC_CHANEL) == k)) begin
          w_hit  = 1'b1;
          w_pick = C_IDX_W'(k);
        end
      end
    end
  end

  // Selected-channel views (constant-index mux keeps widths exact).
  always_comb begin
    w_sel_dat   = '0;
    w_sel_empty = 1'b1;
    w_sel_fcnt  = '0;
    for (int k = 0; k < ADC_CHANEL; k++) begin
      if (r_sel == C_IDX_W'(k)) begin
        w_sel_dat   = ch_data[32*k +: 32];
        w_sel_empty = ch_empty[k];
        w_sel_fcnt  = 16'(r_fcnt[k]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO read strobe. Kept combinational on purpose: a registered strobe would
  // be decided from an empty flag one cycle stale and could over-read a FIFO
  // holding a single word.
  // --------------------------------------------------------------------------
  assign w_rd_go = (r_state == S_PAY) && !w_sel_empty && !data_fifo_almost_full &&
                   (r_issued < C_FRAME_WORDS) && !soft_path_rst;
  assign ch_rden = w_rd_go ? (ADC_CHANEL'(1) << r_sel) : '0;

  // --------------------------------------------------------------------------
  // Optional payload checksum.
  // --------------------------------------------------------------------------
`ifdef FRAME_CSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (soft_path_rst) begin
      r_csum <= '0;
    end else if (r_state == S_HDR) begin
      // No payload is in flight while the header is pending.
      r_csum <= '0;
    end else if (r_rd_d1) begin
      r_csum <= r_csum + w_sel_dat[31:16] + w_sel_dat[15:0];
    end
  end

  assign w_csum = r_csum;
`else
  assign w_csum = 16'h0000;
`endif

  // --------------------------------------------------------------------------
  // Frame FSM with registered write port and status.
  // Payload path: rden in cycle t, FIFO dout valid in t+1 (captured via
  // r_rd_d1), word presented on wr_din in t+2.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100m or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_sel            <= '0;
      r_rr_ptr         <= '0;
      r_issued         <= '0;
      r_written        <= '0;
      r_rd_d1          <= 1'b0;
      data_fifo_wr_en  <= 1'b0;
      data_fifo_wr_din <= '0;
      busy             <= 1'b0;
      cur_chan         <= '0;
      for (int k = 0; k < ADC_CHANEL; k++) r_fcnt[k] <= '0;
    end else if (soft_path_rst) begin
      r_state          <= S_IDLE;
      r_sel            <= '0;
      r_rr_ptr         <= '0;
      r_issued         <= '0;
      r_written        <= '0;
      r_rd_d1          <= 1'b0;
      data_fifo_wr_en  <= 1'b0;
      data_fifo_wr_din <= '0;
      busy             <= 1'b0;
      cur_chan         <= '0;
      for (int k = 0; k < ADC_CHANEL; k++) r_fcnt[k] <= '0;
    end else begin
      data_fifo_wr_en <= 1'b0;
      r_rd_d1         <= w_rd_go;

      // Words already read are always written, regardless of almost_full.
      if (r_rd_d1) begin
        data_fifo_wr_en  <= 1'b1;
        data_fifo_wr_din <= w_sel_dat;
        r_written        <= r_written + C_CNT_W'(1);
      end

      if (w_rd_go) begin
        r_issued <= r_issued + C_CNT_W'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          // busy stays high through the tail write cycle, which is this one.
          if (pack_en && w_hit) begin
            r_sel    <= w_pick;
            r_rr_ptr <= w_pick;
            cur_chan <= 4'(w_pick);
            busy     <= 1'b1;
            r_state  <= S_HDR;
          end else begin
            busy <= 1'b0;
          end
        end

        S_HDR: begin
          if (!data_fifo_almost_full) begin
            data_fifo_wr_en  <= 1'b1;
            data_fifo_wr_din <= {8'hA5, board_number, 4'(r_sel), w_sel_fcnt};
            r_issued         <= '0;
            r_written        <= '0;
            r_state          <= S_PAY;
          end
        end

        S_PAY: begin
          if (r_written == C_FRAME_WORDS) begin
            r_state <= S_TAIL;
          end
        end

        S_TAIL: begin
          if (!data_fifo_almost_full) begin
            data_fifo_wr_en  <= 1'b1;
            data_fifo_wr_din <= {8'h5A, 4'h0, 4'(r_sel), w_csum};
            for (int k = 0; k < ADC_CHANEL; k++) begin
              if (r_sel == C_IDX_W'(k)) r_fcnt[k] <= r_fcnt[k] + FNUM_W'(1);
            end
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad_frame_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_frame_merger
// Purpose  : Directed self-checking bench for ad_frame_merger (N=4,
//            FRAME_WORDS=4). Per-channel FIFOs are modelled with one-cycle
//            read latency; every downstream write is captured and compared
//            against hand-computed frames. Honours FRAME_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_frame_merger;

  logic         clk = 1'b0;
  logic         reset;
  logic         soft_path_rst;
  logic         pack_en;
  logic [3:0]   chan_mask;
  logic [3:0]   board_number;
  logic [3:0]   ch_empty;
  logic [3:0]   ch_rden;
  logic [127:0] ch_data;
  logic         almost_full;
  logic         wr_en;
  logic [31:0]  wr_din;
  logic         busy;
  logic [3:0]   cur_chan;

  ad_frame_merger #(
    .ADC_CHANEL (4),
    .FRAME_WORDS(4),
    .FNUM_W     (16)
  ) dut (
    .clk_100m             (clk),
    .reset                (reset),
    .soft_path_rst        (soft_path_rst),
    .pack_en              (pack_en),
    .chan_mask            (chan_mask),
    .board_number         (board_number),
    .ch_empty             (ch_empty),
    .ch_rden              (ch_rden),
    .ch_data              (ch_data),
    .data_fifo_almost_full(almost_full),
    .data_fifo_wr_en      (wr_en),
    .data_fifo_wr_din     (wr_din),
    .busy                 (busy),
    .cur_chan             (cur_chan)
  );

  initial forever #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- per-channel FIFO model (1-cycle read latency) ----------
  logic [31:0] mem [4][32];
  int          wp [4];
  int          rp [4];
  logic [3:0]  force_e = 4'h0;

  always_comb begin
    for (int k = 0; k < 4; k++) ch_empty[k] = (rp[k] == wp[k]) || force_e[k];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ch_rden[k] && (rp[k] != wp[k])) begin
        ch_data[32*k +: 32] <= mem[k][rp[k] % 32];
        rp[k]               <= rp[k] + 1;
      end
    end
  end

  task automatic push(input int k, input logic [31:0] v);
    mem[k][wp[k] % 32] = v;
    wp[k] = wp[k] + 1;
  endtask

  // ---------------- capture / monitors ----------------
  logic [31:0] cap [64];
  int cap_n, rd_tot, af_rd, gap_wr, cyc, nrd, npw, fpos;
  int rd_cyc [64];
  logic lat_en  = 1'b0;
  logic gap_win = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (cap_n < 64) cap[cap_n] = wr_din;
      cap_n++;
      if (gap_win) gap_wr++;
    end
    if (|ch_rden) begin
      rd_tot++;
      if (almost_full) af_rd++;
    end
    if (lat_en) begin
      if (|ch_rden && nrd < 64) begin
        rd_cyc[nrd] = cyc;
        nrd++;
      end
      if (wr_en) begin
        if (fpos >= 1 && fpos <= 4) begin
          check_eq("pay_latency", cyc - rd_cyc[npw], 2);
          npw++;
        end
        fpos = (fpos == 5) ? 0 : fpos + 1;
      end
    end
  end

  // ---------------- expected-value helpers ----------------
  function automatic logic [31:0] wval(input logic [3:0] k, input int i);
    return 32'hC000_0000 | ({28'h0, k} << 24) | i;
  endfunction

  function automatic logic [15:0] exp_csum(input logic [3:0] k, input int i0);
    logic [15:0] s;
    logic [31:0] w;
    s = 16'h0;
`ifdef FRAME_CSUM_EN
    for (int j = 0; j < 4; j++) begin
      w = wval(k, i0 + j);
      s = s + w[31:16] + w[15:0];
    end
`else
    w = wval(k, i0);
`endif
    return s;
  endfunction

`ifdef FRAME_CSUM_EN
  localparam logic [15:0] C_CSUM_12 = 16'h000C;
`else
  localparam logic [15:0] C_CSUM_12 = 16'h0000;
`endif

  task automatic chk_frame(input string tag, input int base, input logic [3:0] ch,
                           input logic [15:0] fc, input int i0);
    check_eq({tag, "_hdr"}, cap[base], {8'hA5, 4'd3, ch, fc});
    for (int j = 0; j < 4; j++) check_eq({tag, "_pay"}, cap[base + 1 + j], wval(ch, i0 + j));
    check_eq({tag, "_tail"}, cap[base + 5], {8'h5A, 4'h0, ch, exp_csum(ch, i0)});
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (cap_n < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check_eq("words_within_budget", 32'(cap_n >= n), 1);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int c = 0;
    while (rd_tot < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check_eq("rden_within_budget", 32'(rd_tot >= n), 1);
  endtask

  task automatic soft_pulse();
    soft_path_rst = 1'b1;
    @(posedge clk);
    #1 soft_path_rst = 1'b0;
  endtask

  int t1_ch [5] = '{1, 2, 3, 0, 1};
  int t1_i0 [5] = '{0, 0, 0, 0, 4};
  int t1_fc [5] = '{0, 0, 0, 0, 1};
  int snap;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    soft_path_rst = 1'b0;
    pack_en       = 1'b0;
    chan_mask     = 4'hF;
    board_number  = 4'd3;
    almost_full   = 1'b0;

    // ---- reset state ----
    #12;
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cur_chan", cur_chan, 0);
    check_eq("rst_rden", ch_rden, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ---- T1: all channels ready, round robin ch1,2,3,0,1 ----
    for (int k = 0; k < 4; k++) for (int i = 0; i < 4; i++) push(k, wval(4'(k), i));
    for (int i = 4; i < 8; i++) push(1, wval(4'd1, i));
    cap_n = 0; fpos = 0; nrd = 0; npw = 0;
    lat_en  = 1'b1;
    pack_en = 1'b1;
    wait_words(30, 400);
    repeat (10) @(posedge clk);
    #1;
    lat_en = 1'b0;
    check_eq("t1_word_count", cap_n, 30);
    check_eq("t1_first_hdr", cap[0], 32'hA531_0000);
    for (int f = 0; f < 5; f++) chk_frame("t1", 6 * f, 4'(t1_ch[f]), 16'(t1_fc[f]), t1_i0[f]);
    check_eq("t1_latency_count", npw, 20);
    check_eq("t1_busy_idle", busy, 0);
    check_eq("t1_cur_chan_held", cur_chan, 1);

    // ---- T2: soft reset, only ch2 with 8 words -> two frames, fcnt 0 then 1 ----
    soft_pulse();
    check_eq("soft_busy", busy, 0);
    check_eq("soft_wr_en", wr_en, 0);
    check_eq("soft_cur_chan", cur_chan, 0);
    cap_n = 0;
    for (int i = 0; i < 8; i++) push(2, wval(4'd2, 16 + i));
    wait_words(12, 300);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t2_word_count", cap_n, 12);
    chk_frame("t2a", 0, 4'd2, 16'd0, 16);
    chk_frame("t2b", 6, 4'd2, 16'd1, 20);
    check_eq("t2_drained", ch_empty[2], 1);
    check_eq("t2_busy_idle", busy, 0);

    // ---- T3: almost_full raised after the 2nd payload read ----
    soft_pulse();
    cap_n = 0; rd_tot = 0; af_rd = 0;
    for (int i = 0; i < 4; i++) push(0, wval(4'd0, 32 + i));
    wait_rd(2, 100);
    #1 almost_full = 1'b1;
    snap = cap_n;
    repeat (12) @(posedge clk);
    #1;
    check_eq("af_inflight_le3", 32'((cap_n - snap) <= 3), 1);
    check_eq("af_words_held", cap_n, 3);
    check_eq("af_no_rden", af_rd, 0);
    check_eq("af_busy", busy, 1);
    almost_full = 1'b0;
    wait_words(6, 100);
    repeat (5) @(posedge clk);
    #1;
    check_eq("af_word_count", cap_n, 6);
    chk_frame("af", 0, 4'd0, 16'd0, 32);

    // ---- T4: selected FIFO empty for 10 cycles mid-payload ----
    soft_pulse();
    cap_n = 0; rd_tot = 0;
    for (int i = 0; i < 4; i++) push(0, wval(4'd0, 40 + i));
    wait_rd(2, 100);
    #1 force_e[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 gap_wr = 0; gap_win = 1'b1;
    repeat (8) @(posedge clk);
    #1 gap_win = 1'b0;
    check_eq("gap_no_writes", gap_wr, 0);
    check_eq("gap_busy", busy, 1);
    check_eq("gap_words_held", cap_n, 3);
    force_e[0] = 1'b0;
    wait_words(6, 100);
    repeat (10) @(posedge clk);
    #1;
    check_eq("gap_word_count", cap_n, 6);
    chk_frame("gap", 0, 4'd0, 16'd0, 40);

    // ---- T5: checksum field with payload 0x0001_0002 x4 ----
    soft_pulse();
    cap_n = 0;
    for (int i = 0; i < 4; i++) push(0, 32'h0001_0002);
    wait_words(6, 100);
    repeat (3) @(posedge clk);
    #1;
    check_eq("csum_pay", cap[1], 32'h0001_0002);
    check_eq("csum_field", {16'h0, cap[5][15:0]}, {16'h0, C_CSUM_12});
    check_eq("csum_tail", cap[5], {16'h5A00, C_CSUM_12});

    // ---- T6: async reset mid-payload on ch1 (fcnt 1) ----
    cap_n = 0;
    for (int i = 0; i < 4; i++) push(1, wval(4'd1, 48 + i));
    wait_words(6, 100);
    repeat (3) @(posedge clk);
    #1 rd_tot = 0;
    for (int i = 0; i < 4; i++) push(1, wval(4'd1, 52 + i));
    wait_rd(2, 100);
    @(negedge clk);
    check_eq("t6_hdr_fcnt1", cap[6], 32'hA531_0001);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_wr_en", wr_en, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_cur_chan", cur_chan, 0);
    check_eq("arst_rden", ch_rden, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cap_n = 0;
    push(1, wval(4'd1, 56));
    push(1, wval(4'd1, 57));
    wait_words(6, 100);
    #1;
    check_eq("arst_next_hdr", cap[0], 32'hA531_0000);
    check_eq("arst_next_pay0", cap[1], wval(4'd1, 54));
    check_eq("arst_next_pay3", cap[4], wval(4'd1, 57));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
